mips_cpu_instr_memory: RTL
==========================

Name: mips_cpu_instr_memory

Overview:
Instruction-side memory directly upstream of mips_cpu_harvard. It answers the CPU's combinational instruction fetch from a word array mapped at the reset vector.
- Before the CPU runs, the array is cleared and then filled through a streaming load port (valid/ready).
- The block holds the CPU in reset until loading completes, replacing hand-written per-address instruction decode in benches.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words; power of two, at least 4.
BASE_ADDR, 32'hBFC00000, byte address of word 0.
FILL_WORD, 32'h00000000, value for cleared words and unmapped reads (MIPS NOP).

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
clk_enable  in  1  when 0, FSM, pointer and array writes hold
instr_address  in  32  CPU fetch byte address
instr_readdata  out  32  fetched word, byte-reversed into CPU lane order ({b0,b1,b2,b3})
load_start  in  1  pulse; begin a new program load
load_valid  in  1  load_data is valid
load_data  in  32  instruction word, architectural (big-endian) order
load_last  in  1  qualifies the final beat
load_ready  out  1  block accepts a beat
load_done  out  1  program loaded; CPU released
load_error  out  1  sticky; stream overran DEPTH_WORDS
cpu_reset  out  1  active-high reset driven to CPU

Behaviour:
- Reset asserted (reset=0): state=CLEAR, ptr=0, load_ready=0, load_done=0, load_error=0, cpu_reset=1. Array contents are undefined until CLEAR finishes.
- States: CLEAR, IDLE, LOAD, RUN. All transitions require clk_enable=1.
- CLEAR:
  - Writes mem[ptr]=FILL_WORD and increments ptr, one word per cycle.
  - At ptr==DEPTH_WORDS-1, goes to IDLE with ptr=0. CLEAR therefore lasts DEPTH_WORDS cycles.
  - load_start is ignored.
- IDLE: load_ready=0. load_start goes to LOAD with ptr=0 and clears load_error.
- LOAD:
  - load_ready=1. A beat is accepted when load_valid & load_ready: mem[ptr]<=load_data, ptr<=ptr+1.
  - An accepted beat with load_last=1 goes to RUN.
  - An accepted beat at ptr==DEPTH_WORDS-1 without load_last sets load_error=1 and goes to RUN. That last word is stored; later beats see load_ready=0 and are dropped.
  - load_start during LOAD restarts at ptr=0. Previously written words are not re-cleared.
- RUN:
  - load_ready=0, load_done=1.
  - cpu_reset falls on the first clock after entering RUN, giving exactly one RUN cycle with cpu_reset=1.
  - load_start returns to LOAD with ptr=0, load_done=0, and cpu_reset=1 on the same edge.
- cpu_reset=1 in every state other than RUN, and is registered.
- Read path (combinational, zero latency, independent of state):
  - Index is (instr_address-BASE_ADDR)>>2; instr_address[1:0] is ignored.
  - In range (BASE_ADDR <= addr < BASE_ADDR+4*DEPTH_WORDS): instr_readdata = byte-reverse(mem[index]).
  - Otherwise: instr_readdata = byte-reverse(FILL_WORD). This includes address 0, the CPU halt address.
  - The range compare must not wrap at 2^32.
- Read of the word being written in the same cycle returns the old value; the write is visible the next cycle.
- Reset asserted mid-LOAD or in RUN: immediate return to CLEAR with the reset values above.

Optional Feature:
MIPS_IMEM_BOUNDS_CHECK_EN
- Defined: adds output fetch_fault (1 bit, reset 0). It is sticky-set on a rising edge in RUN with cpu_reset=0 when either:
  - instr_address[1:0]!=0, or
  - instr_address is out of range and !=0.
  It clears only on reset or load_start. An assertion message prints the address.
- Undefined: the port is absent and no check logic is generated.

Decomposition:
Package mips_cpu_imem_pkg:
- state enum imem_state_t {CLEAR, IDLE, LOAD, RUN}
- function byte_swap32
- constant MIPS_NOP

Sub-module mips_cpu_imem_array:
- DEPTH_WORDS x 32 array
- one synchronous write port (we, waddr, wdata)
- one asynchronous read port

Top keeps the FSM, pointer, range decode and swap.

Test Plan:
- Reset, then 1024 cycles -> load_ready 0 throughout CLEAR; IDLE reached at cycle 1024; read at 0xBFC00010 returns 0x00000000.
- load_start, stream 6 words 0x0BF00004, 0x24210001, 0x00000008, 0x24020002, 0x1420FFFD, 0x24000000 with last on word 6 -> load_done=1; cpu_reset falls one cycle later; read at 0xBFC00004 returns 0x01002124.
- Same stream with load_valid toggled 1,0,1,0 and clk_enable low 3 cycles mid-stream -> all 6 words stored; ptr frozen while disabled.
- DEPTH_WORDS=4, stream 6 beats no last -> load_error=1 after beat 4; beats 5-6 see load_ready=0; mem[3]=beat 4.
- Reads at 0x00000000, 0xBFBFFFFC, 0xBFC01000 (depth 1024) -> all return 0x00000000; with MIPS_IMEM_BOUNDS_CHECK_EN, address 0 does not set fetch_fault but 0xBFC01000 and 0xBFC00002 do.
- Reset deasserted-to-asserted mid-LOAD after 3 beats -> cpu_reset=1 and load_ready=0 asynchronously; re-CLEAR; prior words read as 0 after CLEAR.

Source files
------------

// File: rtl/mips_cpu_imem_pkg.sv
// Shared definitions for the MIPS instruction-side memory.
//   imem_state_t : loader FSM states (CLEAR, IDLE, LOAD, RUN)
//   MIPS_NOP     : all-zero word, used for cleared and unmapped locations
//   byte_swap32  : reverses byte order between architectural (big-endian)
//                  order and the CPU's lane order
package mips_cpu_imem_pkg;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    LOAD  = 2'd2,
    RUN   = 2'd3
  } imem_state_t;

  localparam logic [31:0] MIPS_NOP = 32'h0000_0000;

  function automatic logic [31:0] byte_swap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/mips_cpu_imem_array.sv
// Word storage for the instruction memory.
//   clk   : write clock
//   we    : write enable, one word per rising edge
//   waddr : write word index
//   wdata : write data
//   raddr : asynchronous read word index
//   rdata : asynchronous read data (old value while a write to the same
//           index is pending; the write lands on the clock edge)
module mips_cpu_imem_array #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mips_cpu_instr_memory.sv
// Instruction memory feeding mips_cpu_harvard. Clears its array after reset,
// accepts a program over a valid/ready stream, then releases the CPU.
//   clk, reset (async, active-low), clk_enable (freezes FSM/pointer/writes)
//   instr_address / instr_readdata : combinational fetch, byte-swapped
//   load_start, load_valid, load_data, load_last, load_ready : load stream
//   load_done, load_error (sticky overrun), cpu_reset (to CPU, registered)
// Optional macro MIPS_IMEM_BOUNDS_CHECK_EN adds output fetch_fault, a sticky
// flag for misaligned or unmapped fetches while the CPU runs.
module mips_cpu_instr_memory
  import mips_cpu_imem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'hBFC0_0000,
  parameter logic [31:0] FILL_WORD   = MIPS_NOP
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic [31:0] instr_address,
  output logic [31:0] instr_readdata,
  input  logic        load_start,
  input  logic        load_valid,
  input  logic [31:0] load_data,
  input  logic        load_last,
  output logic        load_ready,
  output logic        load_done,
  output logic        load_error,
  output logic        cpu_reset
`ifdef MIPS_IMEM_BOUNDS_CHECK_EN
  ,
  output logic        fetch_fault
`endif
);

  localparam int unsigned   AW         = $clog2(DEPTH_WORDS);
  localparam logic [AW-1:0] LAST_PTR   = AW'(DEPTH_WORDS - 1);
  localparam logic [32:0]   SPAN_BYTES = 33'(DEPTH_WORDS) << 2;

  imem_state_t   state_reg;
  logic [AW-1:0] ptr_reg;
  logic          load_ready_reg;
  logic          load_done_reg;
  logic          load_error_reg;
  logic          cpu_reset_reg;

  // A start request wins over a beat presented on the same edge.
  logic restart;
  logic beat;
  assign restart = clk_enable && load_start && (state_reg != CLEAR);
  assign beat    = clk_enable && load_valid && load_ready_reg && !restart;

  logic        mem_we;
  logic [31:0] mem_wdata;
  assign mem_we    = clk_enable && ((state_reg == CLEAR) || beat);
  assign mem_wdata = (state_reg == CLEAR) ? FILL_WORD : load_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= CLEAR;
      ptr_reg        <= '0;
      load_ready_reg <= 1'b0;
      load_done_reg  <= 1'b0;
      load_error_reg <= 1'b0;
      cpu_reset_reg  <= 1'b1;
    end else if (clk_enable) begin
      if (restart) begin
        state_reg      <= LOAD;
        ptr_reg        <= '0;
        load_ready_reg <= 1'b1;
        load_done_reg  <= 1'b0;
        load_error_reg <= 1'b0;
        cpu_reset_reg  <= 1'b1;
      end else begin
        case (state_reg)
          CLEAR: begin
            if (ptr_reg == LAST_PTR) begin
              state_reg <= IDLE;
              ptr_reg   <= '0;
            end else begin
              ptr_reg <= ptr_reg + AW'(1);
            end
          end
          IDLE: begin
            load_ready_reg <= 1'b0;
          end
          LOAD: begin
            if (beat) begin
              ptr_reg <= ptr_reg + AW'(1);
              // Final word or a full array both end the load; the latter
              // without load_last is an overrun.
              if (load_last || (ptr_reg == LAST_PTR)) begin
                state_reg      <= RUN;
                load_ready_reg <= 1'b0;
                load_done_reg  <= 1'b1;
                if (!load_last) begin
                  load_error_reg <= 1'b1;
                end
              end
            end
          end
          RUN: begin
            // Entry edge keeps cpu_reset high; it drops on the next one.
            cpu_reset_reg <= 1'b0;
          end
          default: begin
            state_reg <= CLEAR;
          end
        endcase
      end
    end
  end

  // Range check done in 33 bits so a window touching 2^32 cannot wrap.
  logic          in_range;
  logic [AW-1:0] raddr;
  logic [31:0]   rword;
  assign in_range = ({1'b0, instr_address} >= {1'b0, BASE_ADDR}) &&
                    ({1'b0, instr_address} <  ({1'b0, BASE_ADDR} + SPAN_BYTES));
  assign raddr    = AW'((instr_address - BASE_ADDR) >> 2);

  mips_cpu_imem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .waddr (ptr_reg),
    .wdata (mem_wdata),
    .raddr (raddr),
    .rdata (rword)
  );

  assign instr_readdata = byte_swap32(in_range ? rword : FILL_WORD);

  assign load_ready = load_ready_reg;
  assign load_done  = load_done_reg;
  assign load_error = load_error_reg;
  assign cpu_reset  = cpu_reset_reg;

`ifdef MIPS_IMEM_BOUNDS_CHECK_EN
  // Address 0 is the CPU halt address and is a legal out-of-range fetch.
  logic fault_hit;
  logic fetch_fault_reg;
  assign fault_hit = (state_reg == RUN) && !cpu_reset_reg &&
                     ((instr_address[1:0] != 2'b00) ||
                      (!in_range && (instr_address != 32'h0000_0000)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_fault_reg <= 1'b0;
    end else if (restart) begin
      fetch_fault_reg <= 1'b0;
    end else if (fault_hit) begin
      fetch_fault_reg <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      assert (!fault_hit)
        else $warning("instruction fetch fault at address 0x%08h", instr_address);
    end
  end

  assign fetch_fault = fetch_fault_reg;
`endif

endmodule
